// File: rtl/nmea_sentence_parser.sv
// rtl/nmea_sentence_parser.sv - NMEA-0183 sentence filter, field splitter and atomic committer
//
// Purpose: consumes the ASCII byte stream from the GPS UART receiver, keeps only sentences
//   whose talker+type equals MSG_TYPE, splits their comma-delimited fields into a shadow
//   buffer, and commits the whole field set to the output registers on a clean end of line.
//   Optional macro NMEA_CHECKSUM_EN: when defined the '*hh' checksum is verified and a
//   sentence must carry one; when undefined the two digits are skipped unchecked and a CR
//   inside a field also terminates the sentence.
//
// Ports:
//   sclk          in   system clock
//   rstn          in   asynchronous active-low reset
//   rx_data       in   received byte
//   rx_valid      in   rx_data valid this cycle (no backpressure)
//   fields        out  committed chars, field k char j at [(k*FIELD_CHARS+j)*8 +: 8]
//   field_len     out  committed lengths, field k at [k*LW +: LW]
//   field_cnt     out  number of fields in the last committed sentence (saturating)
//   frame_strobe  out  1-cycle pulse on commit
//   frame_err     out  1-cycle pulse on a discarded sentence
//   gps_ready     out  fix valid according to the last committed sentence
module nmea_sentence_parser #(
  parameter logic [39:0] MSG_TYPE    = "GPGGA",
  parameter int          MAX_FIELDS  = 14,
  parameter int          FIELD_CHARS = 10,
  parameter int          QUAL_IDX    = 5,
  localparam int         LW          = $clog2(FIELD_CHARS + 1),
  localparam int         CW          = $clog2(MAX_FIELDS + 1)
) (
  input  logic                                sclk,
  input  logic                                rstn,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic [MAX_FIELDS*FIELD_CHARS*8-1:0] fields,
  output logic [MAX_FIELDS*LW-1:0]            field_len,
  output logic [CW-1:0]                       field_cnt,
  output logic                                frame_strobe,
  output logic                                frame_err,
  output logic                                gps_ready
);

  localparam logic [7:0]    CH_DOLLAR = 8'h24;
  localparam logic [7:0]    CH_COMMA  = 8'h2C;
  localparam logic [7:0]    CH_STAR   = 8'h2A;
  localparam logic [7:0]    CH_CR     = 8'h0D;
  localparam logic [7:0]    CH_LF     = 8'h0A;
  localparam logic [7:0]    CH_ZERO   = 8'h30;
  localparam logic [CW-1:0] MAXF      = CW'(MAX_FIELDS);
  localparam logic [LW-1:0] FCH       = LW'(FIELD_CHARS);
  localparam logic [CW-1:0] QIDX      = CW'(QUAL_IDX);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FIELD, S_CS_HI, S_CS_LO, S_EOL
  } state_t;

  typedef logic [MAX_FIELDS-1:0][FIELD_CHARS-1:0][7:0] chars_t;
  typedef logic [MAX_FIELDS-1:0][LW-1:0]               lens_t;

  state_t        state_q, state_d;
  logic [2:0]    hdr_cnt_q, hdr_cnt_d;
  logic [CW-1:0] fidx_q, fidx_d;       // saturates at MAX_FIELDS: "beyond storage"
  logic          trunc_q, trunc_d;
  logic          cr_seen_q, cr_seen_d;
  chars_t        sh_char_q, sh_char_d;
  lens_t         sh_len_q, sh_len_d;

  chars_t        out_char_q, out_char_d;
  lens_t         out_len_q, out_len_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;

  logic [CW-1:0] cnt_new;

`ifdef NMEA_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] cs_rx_q, cs_rx_d;

  // {valid, nibble}; accepts 0-9, A-F, a-f
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
                                       return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  logic [4:0] hex_nib;
  assign hex_nib = hex_dec(rx_data);
`endif

  assign cnt_new = (fidx_q == MAXF) ? fidx_q : fidx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    fidx_d     = fidx_q;
    trunc_d    = trunc_q;
    cr_seen_d  = cr_seen_q;
    sh_char_d  = sh_char_q;
    sh_len_d   = sh_len_q;
    out_char_d = out_char_q;
    out_len_d  = out_len_q;
    out_cnt_d  = out_cnt_q;
    ready_d    = ready_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
`ifdef NMEA_CHECKSUM_EN
    csum_d     = csum_q;
    cs_rx_d    = cs_rx_q;
`endif

    if (rx_valid) begin
      if (rx_data == CH_DOLLAR) begin
        // '$' always restarts; only a sentence already past its header counts as lost
        err_d     = (state_q != S_IDLE) && (state_q != S_HDR);
        state_d   = S_HDR;
        hdr_cnt_d = 3'd0;
        fidx_d    = '0;
        trunc_d   = 1'b0;
        cr_seen_d = 1'b0;
        sh_char_d = '0;
        sh_len_d  = '0;
`ifdef NMEA_CHECKSUM_EN
        csum_d    = 8'h00;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
          end

          S_HDR: begin
`ifdef NMEA_CHECKSUM_EN
            csum_d = csum_q ^ rx_data;
`endif
            if (hdr_cnt_q < 3'd5) begin
              // first type character sits in the MSBs of MSG_TYPE
              if (rx_data == MSG_TYPE[8*(4-int'(hdr_cnt_q)) +: 8]) hdr_cnt_d = hdr_cnt_q + 3'd1;
              else state_d = S_IDLE;   // other sentence types are ignored silently
            end else if (rx_data == CH_COMMA) begin
              state_d = S_FIELD;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end

          S_FIELD: begin
            if (rx_data == CH_STAR) begin
              state_d = S_CS_HI;
            end else if (rx_data == CH_CR || rx_data == CH_LF) begin
`ifdef NMEA_CHECKSUM_EN
              err_d   = 1'b1;
              state_d = S_IDLE;
`else
              if (rx_data == CH_CR) begin
                state_d   = S_EOL;
                cr_seen_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
`endif
            end else begin
`ifdef NMEA_CHECKSUM_EN
              csum_d = csum_q ^ rx_data;
`endif
              if (rx_data == CH_COMMA) begin
                if (fidx_q != MAXF) fidx_d = fidx_q + 1'b1;
              end else if (fidx_q < MAXF) begin
                if (sh_len_q[fidx_q] < FCH) begin
                  sh_char_d[fidx_q][sh_len_q[fidx_q]] = rx_data;
                  sh_len_d[fidx_q] = sh_len_q[fidx_q] + 1'b1;
                end else begin
                  trunc_d = 1'b1;
                end
              end
            end
          end

          S_CS_HI: begin
`ifdef NMEA_CHECKSUM_EN
            if (hex_nib[4]) begin
              cs_rx_d[7:4] = hex_nib[3:0];
              state_d      = S_CS_LO;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
`else
            state_d = S_CS_LO;
`endif
          end

          S_CS_LO: begin
            cr_seen_d = 1'b0;
`ifdef NMEA_CHECKSUM_EN
            if (hex_nib[4]) begin
              cs_rx_d[3:0] = hex_nib[3:0];
              state_d      = S_EOL;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
`else
            state_d = S_EOL;
`endif
          end

          S_EOL: begin
            state_d = S_IDLE;
            if (!cr_seen_q) begin
              if (rx_data == CH_CR) begin
                cr_seen_d = 1'b1;
                state_d   = S_EOL;
              end else begin
                err_d = 1'b1;
              end
            end else if (rx_data != CH_LF || trunc_q
`ifdef NMEA_CHECKSUM_EN
                         || (cs_rx_q != csum_q)
`endif
                        ) begin
              err_d = 1'b1;
            end else begin
              // whole field set moves to the outputs in one edge
              strobe_d   = 1'b1;
              out_char_d = sh_char_q;
              out_len_d  = sh_len_q;
              out_cnt_d  = cnt_new;
              ready_d    = (QIDX < cnt_new) && (sh_len_q[QUAL_IDX] != '0) &&
                           (sh_char_q[QUAL_IDX][0] != CH_ZERO);
            end
          end

          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= 3'd0;
      fidx_q     <= '0;
      trunc_q    <= 1'b0;
      cr_seen_q  <= 1'b0;
      sh_char_q  <= '0;
      sh_len_q   <= '0;
      out_char_q <= '0;
      out_len_q  <= '0;
      out_cnt_q  <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
      csum_q     <= 8'h00;
      cs_rx_q    <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      fidx_q     <= fidx_d;
      trunc_q    <= trunc_d;
      cr_seen_q  <= cr_seen_d;
      sh_char_q  <= sh_char_d;
      sh_len_q   <= sh_len_d;
      out_char_q <= out_char_d;
      out_len_q  <= out_len_d;
      out_cnt_q  <= out_cnt_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
`ifdef NMEA_CHECKSUM_EN
      csum_q     <= csum_d;
      cs_rx_q    <= cs_rx_d;
`endif
    end
  end

  assign fields       = out_char_q;
  assign field_len    = out_len_q;
  assign field_cnt    = out_cnt_q;
  assign frame_strobe = strobe_q;
  assign frame_err    = err_q;
  assign gps_ready    = ready_q;

endmodule

// File: tb/tb_nmea_sentence_parser.sv
// tb/tb_nmea_sentence_parser.sv - scoreboard bench for nmea_sentence_parser
module tb_nmea_sentence_parser;

  logic         sclk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [1119:0] fields;
  logic [55:0]  field_len;
  logic [3:0]   field_cnt;
  logic         frame_strobe, frame_err, gps_ready;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    int          cnt;
    bit          ready;
    logic [79:0] f0;
    int          f0len;
    logic [79:0] f1;
    int          f1len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t last;
  exp_t e1;
  exp_t ev_err;

  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  nmea_sentence_parser dut (
    .sclk(sclk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .fields(fields), .field_len(field_len), .field_cnt(field_cnt),
    .frame_strobe(frame_strobe), .frame_err(frame_err), .gps_ready(gps_ready)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [79:0] pk(input string s);
    logic [79:0] v = '0;
    for (int i = 0; i < s.len() && i < 10; i++) v[i*8 +: 8] = s[i];
    return v;
  endfunction

  function automatic exp_t mk_exp(input int cnt, input bit rdy, input string f0, input string f1);
    exp_t e;
    e.is_err = 1'b0; e.cnt = cnt; e.ready = rdy;
    e.f0 = pk(f0); e.f0len = f0.len();
    e.f1 = pk(f1); e.f1len = f1.len();
    return e;
  endfunction

  // "$" + body + "*HH" with the XOR checksum of body
  function automatic string mk(input string body);
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < body.len(); i++) cs ^= body[i];
    return {"$", body, "*", $sformatf("%02X", cs)};
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_cnt"},   field_cnt,       e.cnt[3:0]);
    chk({tag, "_ready"}, gps_ready,       e.ready);
    chk({tag, "_f0"},    fields[79:0],    e.f0);
    chk({tag, "_f0len"}, field_len[3:0],  e.f0len[3:0]);
    chk({tag, "_f1"},    fields[159:80],  e.f1);
    chk({tag, "_f1len"}, field_len[7:4],  e.f1len[3:0]);
  endtask

  always @(negedge sclk) begin
    if (rstn && (frame_strobe || frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_event strobe=%0b err=%0b required=none", frame_strobe, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_err",    frame_err,    mon_e.is_err);
        chk("event_strobe", frame_strobe, !mon_e.is_err);
        if (!mon_e.is_err && frame_strobe) begin
          chk("strobe_after_lf", {prev_valid, prev_data}, {1'b1, 8'h0A});
          chk_out("commit", mon_e);
        end
      end
    end
    prev_valid <= rx_valid;
    prev_data  <= rx_data;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(posedge sclk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge sclk); #1; end
  endtask

  task automatic send_raw(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(maxgap, 0));
  endtask

  task automatic send_line(input string s, input int maxgap);
    send_raw(s, maxgap);
    send_byte(8'h0D, $urandom_range(maxgap, 0));
    send_byte(8'h0A, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge sclk); #1; end
    repeat (3) begin @(posedge sclk); #1; end
    chk({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  localparam string S1 = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47";

  initial begin
    ev_err = '{is_err: 1'b1, cnt: 0, ready: 1'b0, f0: '0, f0len: 0, f1: '0, f1len: 0};
    e1 = mk_exp(14, 1'b1, "123519", "4807.038");

    repeat (3) @(posedge sclk);
    #1;
    chk("reset_strobe", frame_strobe, 0);
    chk("reset_err", frame_err, 0);
    chk("reset_fields", fields, 0);
    chk_out("reset", mk_exp(0, 1'b0, "", ""));
    rstn = 1'b1;
    @(posedge sclk); #1;

    // 1: reference sentence
    exp_q.push_back(e1); last = e1;
    send_line(S1, 0);
    drain("t1");
    chk("t1_f5", fields[5*80 +: 8], 8'h31);
    chk("t1_f5len", field_len[5*4 +: 4], 1);

    // 2: wrong checksum
`ifdef NMEA_CHECKSUM_EN
    exp_q.push_back(ev_err);
`else
    exp_q.push_back(e1);
`endif
    send_line("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48", 0);
    drain("t2");
    chk_out("t2_hold", e1);

    // 3: other sentence type is ignored, then quality '0'
    send_line("$GPRMC,123519,A*00", 0);
    drain("t3a");
    chk_out("t3_hold", e1);
    last = mk_exp(6, 1'b0, "000001", "");
    exp_q.push_back(last);
    send_line(mk("GPGGA,000001,,,,,0"), 1);
    drain("t3b");

    // lowercase checksum digit (XOR of "GPGGA,1" is 0x4B)
    last = mk_exp(1, 1'b0, "1", "");
    exp_q.push_back(e1);
    send_line(S1, 0);
    exp_q.push_back(last);
    send_line("$GPGGA,1*4b", 0);
    drain("t_lower");

    // quality field index beyond field_cnt
    exp_q.push_back(e1);
    send_line(S1, 0);
    last = mk_exp(1, 1'b0, "777", "");
    exp_q.push_back(last);
    send_line(mk("GPGGA,777"), 0);
    drain("t_short");

    // 4: 11-char field -> error, outputs held
    exp_q.push_back(ev_err);
    send_line(mk("GPGGA,12345678901,1"), 0);
    drain("t4");
    chk_out("t4_hold", last);

    // exactly FIELD_CHARS chars is accepted
    last = mk_exp(6, 1'b1, "1234567890", "x");
    exp_q.push_back(last);
    send_line(mk("GPGGA,1234567890,x,,,,2"), 0);
    drain("t_full");

    // field count saturation at MAX_FIELDS
    last = mk_exp(14, 1'b1, "A", "");
    exp_q.push_back(last);
    send_line(mk("GPGGA,A,,,,,1,,,,,,,,,,,,Z"), 0);
    drain("t_sat");

    // LF without CR
    exp_q.push_back(ev_err);
    send_raw("$GPGGA,1*4b", 0);
    send_byte(8'h0A, 0);
    drain("t_nocr");
    chk_out("t_nocr_hold", last);

    // non-hex checksum digit and CR inside a field
`ifdef NMEA_CHECKSUM_EN
    exp_q.push_back(ev_err);
    send_line("$GPGGA,1*4G", 0);
    exp_q.push_back(ev_err);
    send_byte(8'h24, 0); send_raw("GPGGA,55", 0);
    send_byte(8'h0D, 0); send_byte(8'h0A, 0);
`else
    last = mk_exp(1, 1'b0, "1", "");
    exp_q.push_back(last);
    send_line("$GPGGA,1*4G", 0);
    last = mk_exp(1, 1'b0, "55", "");
    exp_q.push_back(last);
    send_byte(8'h24, 0); send_raw("GPGGA,55", 0);
    send_byte(8'h0D, 0); send_byte(8'h0A, 0);
`endif
    drain("t_misc");
    chk_out("t_misc_hold", last);

    // 5: '$' mid-field, then a valid sentence
    exp_q.push_back(ev_err);
    exp_q.push_back(e1);
    send_raw("$GPGGA,1235", 0);
    send_line(S1, 0);
    drain("t5");

    // 6: asynchronous reset mid-sentence, then gapped stream
    send_raw("$GPGGA,12", 0);
    #3 rstn = 1'b0;
    #1;
    chk("t6_fields", fields, 0);
    chk("t6_lens", field_len, 0);
    chk("t6_cnt", field_cnt, 0);
    chk("t6_ready", gps_ready, 0);
    chk("t6_pulses", {frame_strobe, frame_err}, 0);
    @(negedge sclk);
    rstn = 1'b1;
    @(posedge sclk); #1;
    exp_q.push_back(e1);
    send_line(S1, 7);
    drain("t6");
    chk("t6_f5", fields[5*80 +: 8], 8'h31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
